seq_det: RTL and testbench

Serial pattern detector and frame-lock checker that sits directly downstream of the sequence generator. It consumes the qualified serial stream (`seq_signal` gated by `seq_en`) and detects every occurrence of a PAT_LEN-bit pattern. It locks onto the pattern's expected period and flags missing occurrences as errors. Match and error counts go to status logic.

---
 rtl/seq_det.sv | 176 +++++++++++++++++
 tb/tb_seq_det.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det.sv
// seq_det: serial pattern detector with frame-lock tracking.
// Watches the qualified serial stream for PATTERN (MSB received first), locks
// onto its PERIOD-bit repetition after LOCK_CNT on-period matches, and flags
// each expected-position miss while locked. Lock is dropped after LOSS_CNT
// consecutive misses.
// Optional feature macro: SEQ_DET_ERRCNT_EN (when undefined, err_cnt is tied to 0).
module seq_det #(
    parameter int                 PAT_LEN  = 8,
    parameter logic [PAT_LEN-1:0] PATTERN  = PAT_LEN'(8'b11100100),
    parameter int                 PERIOD   = 8,
    parameter int                 LOCK_CNT = 3,
    parameter int                 LOSS_CNT = 2,
    parameter int                 CNT_W    = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             seq_en,
    input  logic             seq_signal,
    input  logic             cnt_clr,
    output logic             det_pulse,
    output logic             err_pulse,
    output logic             locked,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int FILL_W = $clog2(PAT_LEN);
    localparam int PH_W   = $clog2(PERIOD);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [PAT_LEN-2:0]  win;
    logic [FILL_W-1:0]   fill;
    logic [PH_W-1:0]     phase, phase_nxt;
    logic [GOOD_W-1:0]   good, good_nxt;
    logic [MISS_W-1:0]   miss, miss_nxt;
    logic                err_hit;
    logic                win_full;
    logic                match;
    logic                at_expected;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Only the last PAT_LEN-1 bits are stored; the live bit completes the window.
    assign win_full    = (fill == FILL_W'(PAT_LEN - 1));
    assign match       = seq_en && win_full && ({win, seq_signal} == PATTERN);
    assign at_expected = (phase == PH_W'(PERIOD - 1));

    // Window shift and fill tracking on every valid bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win  <= '0;
            fill <= '0;
        end else if (seq_en) begin
            win <= (PAT_LEN-1)'({win, seq_signal});
            if (!win_full) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // FSM state, phase and good/miss bookkeeping registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= HUNT;
            phase <= '0;
            good  <= '0;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            good  <= good_nxt;
            miss  <= miss_nxt;
        end
    end

    // Next-state logic: only valid bits advance anything; expected positions drive lock decisions.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        good_nxt  = good;
        miss_nxt  = miss;
        err_hit   = 1'b0;
        if (seq_en) begin
            phase_nxt = at_expected ? '0 : phase + 1'b1;
            case (state)
                HUNT: begin
                    if (match) begin
                        state_nxt = VERIFY;
                        good_nxt  = GOOD_W'(1);
                        phase_nxt = '0;
                    end
                end
                VERIFY: begin
                    if (at_expected) begin
                        if (match) begin
                            good_nxt = good + 1'b1;
                            if (good + 1'b1 == GOOD_W'(LOCK_CNT)) begin
                                state_nxt = LOCK;
                                miss_nxt  = '0;
                            end
                        end else begin
                            state_nxt = HUNT;
                        end
                    end
                end
                LOCK: begin
                    if (at_expected) begin
                        if (match) begin
                            miss_nxt = '0;
                        end else begin
                            err_hit  = 1'b1;
                            miss_nxt = miss + 1'b1;
                            if (miss + 1'b1 == MISS_W'(LOSS_CNT)) begin
                                state_nxt = HUNT;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                end
            endcase
        end
    end

    // Registered pulses and lock flag, aligned with the state update.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            det_pulse <= 1'b0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            det_pulse <= match;
            err_pulse <= err_hit;
            locked    <= (state_nxt == LOCK);
        end
    end

    // Match counter: clear has priority over a simultaneous increment.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match) begin
            match_cnt <= sat_inc(match_cnt);
        end
    end

`ifdef SEQ_DET_ERRCNT_EN
    // Error counter: clear has priority over a simultaneous increment.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (err_hit) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det.sv
// Scoreboard bench for seq_det: a bit-history reference model predicts every
// cycle's outputs; a monitor compares them one cycle later. A second instance
// with 2-bit counters exercises saturation on the same stimulus.
module tb_seq_det;

    localparam logic [7:0] PAT = 8'b11100100;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        seq_en;
    logic        seq_signal;
    logic        cnt_clr;
    logic        det_pulse, err_pulse, locked;
    logic [15:0] match_cnt, err_cnt;
    logic        det2, err2, locked2;
    logic [1:0]  mc2, ec2;

    seq_det dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .seq_en(seq_en),
        .seq_signal(seq_signal), .cnt_clr(cnt_clr), .det_pulse(det_pulse),
        .err_pulse(err_pulse), .locked(locked), .match_cnt(match_cnt),
        .err_cnt(err_cnt)
    );

    seq_det #(.CNT_W(2)) dut_sat (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .seq_en(seq_en),
        .seq_signal(seq_signal), .cnt_clr(cnt_clr), .det_pulse(det2),
        .err_pulse(err2), .locked(locked2), .match_cnt(mc2),
        .err_cnt(ec2)
    );

    typedef struct packed {
        logic        det;
        logic        err;
        logic        lck;
        logic [15:0] mc;
        logic [15:0] ec;
        logic        det2;
        logic        err2;
        logic        lck2;
        logic [1:0]  mc2;
        logic [1:0]  ec2;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: remembers raw bits and the valid-bit index of the anchor.
    bit hist[$];
    int m_mode;     // 0 hunting, 1 verifying, 2 locked
    int m_good, m_miss, m_vcnt, m_anchor;
    int m_mc, m_ec, m_mc2, m_ec2;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic obs_t sample();
        obs_t o;
        o.det = det_pulse; o.err = err_pulse; o.lck = locked;
        o.mc = match_cnt; o.ec = err_cnt;
        o.det2 = det2; o.err2 = err2; o.lck2 = locked2;
        o.mc2 = mc2; o.ec2 = ec2;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual det=%b err=%b lck=%b mc=%0d ec=%0d | det2=%b err2=%b lck2=%b mc2=%0d ec2=%0d ; expected det=%b err=%b lck=%b mc=%0d ec=%0d | det2=%b err2=%b lck2=%b mc2=%0d ec2=%0d",
                     name, $time, act.det, act.err, act.lck, act.mc, act.ec,
                     act.det2, act.err2, act.lck2, act.mc2, act.ec2,
                     exp.det, exp.err, exp.lck, exp.mc, exp.ec,
                     exp.det2, exp.err2, exp.lck2, exp.mc2, exp.ec2);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_mode = 0; m_good = 0; m_miss = 0; m_vcnt = 0; m_anchor = 0;
        m_mc = 0; m_ec = 0; m_mc2 = 0; m_ec2 = 0;
    endtask

    function automatic obs_t model_step(input bit en, input bit b, input bit clr);
        obs_t e;
        bit det = 0, err = 0, hit, expd;
        int v = 0;
        if (en) begin
            m_vcnt++;
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            foreach (hist[i]) v = (v << 1) | int'(hist[i]);
            hit  = (hist.size() == 8) && (v == int'(PAT));
            expd = (m_mode != 0) && (((m_vcnt - m_anchor) % 8) == 0);
            case (m_mode)
                0: if (hit) begin m_mode = 1; m_good = 1; m_anchor = m_vcnt; end
                1: if (expd) begin
                       if (hit) begin
                           m_good++;
                           if (m_good == 3) begin m_mode = 2; m_miss = 0; end
                       end else m_mode = 0;
                   end
                default: if (expd) begin
                       if (hit) m_miss = 0;
                       else begin
                           err = 1; m_miss++;
                           if (m_miss == 2) m_mode = 0;
                       end
                   end
            endcase
            det = hit;
        end
        if (clr) begin
            m_mc = 0; m_ec = 0; m_mc2 = 0; m_ec2 = 0;
        end else begin
            if (det) begin
                if (m_mc < 65535) m_mc++;
                if (m_mc2 < 3) m_mc2++;
            end
            if (err) begin
                if (m_ec < 65535) m_ec++;
                if (m_ec2 < 3) m_ec2++;
            end
        end
        e.det = det; e.err = err; e.lck = (m_mode == 2);
        e.det2 = det; e.err2 = err; e.lck2 = (m_mode == 2);
        e.mc = 16'(m_mc); e.mc2 = 2'(m_mc2);
`ifdef SEQ_DET_ERRCNT_EN
        e.ec = 16'(m_ec); e.ec2 = 2'(m_ec2);
`else
        e.ec = '0; e.ec2 = '0;
`endif
        return e;
    endfunction

    // One cycle of stimulus: drive on the falling edge, predict, queue the prediction.
    task automatic drive(input bit rst, input bit en, input bit b, input bit clr);
        obs_t e;
        @(negedge sys_clk);
        sys_rst_n = !rst; seq_en = en; seq_signal = b; cnt_clr = clr;
        if (rst) begin
            model_reset();
            e = '0;
        end else begin
            e = model_step(en, b, clr);
        end
        exp_q.push_back(e);
        if (rst) begin
            #1;
            compare("reset_immediate", sample(), obs_t'(0));
        end
    endtask

    // One pattern period; gap 0 none, 1 alternate idle, 2 random idles.
    task automatic send_period(input int corrupt, input int gap, input int clr_at);
        bit b;
        for (int i = 0; i < 8; i++) begin
            if (gap == 2) begin
                int n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) drive(0, 0, 1'($urandom), 0);
            end
            b = PAT[7-i];
            if (i == corrupt) b = ~b;
            drive(0, 1, b, i == clr_at);
            if (gap == 1) drive(0, 0, 1'($urandom), 0);
        end
    endtask

    // Monitor: pops one prediction per cycle and compares the registered outputs.
    initial begin
        obs_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("scoreboard", sample(), e);
            end
        end
    end

    initial begin
        sys_rst_n = 1'b0; seq_en = 1'b0; seq_signal = 1'b0; cnt_clr = 1'b0;
        model_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);

        // Clean lock from reset.
        for (int p = 0; p < 3; p++) send_period(-1, 0, -1);
        @(posedge sys_clk); #1;
        n_vec++;
        if (locked !== 1'b1 || match_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL clean_lock actual locked=%b match_cnt=%0d expected locked=1 match_cnt=3", locked, match_cnt);
        end

        // Single corruption, then loss of lock and re-acquire.
        send_period(-1, 0, -1);
        send_period(3, 0, -1);
        send_period(-1, 0, -1);
        send_period(-1, 0, -1);
        send_period(0, 0, -1);
        send_period(6, 0, -1);
        for (int p = 0; p < 4; p++) send_period(-1, 0, -1);
        @(posedge sys_clk); #1;
        n_vec++;
        if (mc2 !== 2'd3) begin
            n_err++;
            $display("FAIL saturation actual mc2=%0d expected 3", mc2);
        end

        // Reset while locked, then refill.
        drive(1, 1, 1, 0);
        for (int p = 0; p < 3; p++) send_period(-1, 0, -1);

        // Alternating enable gaps from reset.
        drive(1, 0, 0, 0);
        for (int p = 0; p < 4; p++) send_period(-1, 1, -1);

        // Clear coinciding with a match.
        send_period(-1, 0, 7);
        send_period(-1, 0, -1);

        // Randomized mix of clean, corrupted, misaligned, gapped and cleared periods.
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_period(-1, ($urandom_range(0, 3) == 0) ? 2 : 0, -1);
                4:          send_period(-1, 1, -1);
                5, 6:       send_period($urandom_range(0, 7), 0, -1);
                7: begin
                    int n = $urandom_range(1, 5);
                    for (int k = 0; k < n; k++) drive(0, 1, 1'($urandom), 0);
                end
                8:          send_period(-1, 0, $urandom_range(0, 7));
                default: begin
                    if ($urandom_range(0, 3) == 0) drive(1, 1'($urandom), 1'($urandom), 0);
                    else send_period(-1, 0, -1);
                end
            endcase
        end

        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(posedge sys_clk); #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain actual pending=%0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
